// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared system bus with a maximum-tenure limit.
// Optional macro BUS_ARB_LOCK_EN adds the m_lock_ port, which lets the owner hold the bus past MAX_HOLD.
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = $clog2(NUM_MASTERS),
  parameter int MAX_HOLD    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_req_,
`ifdef BUS_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0] m_lock_,
`endif
  output logic [NUM_MASTERS-1:0] m_grnt_,
  output logic [OWNER_W-1:0]     owner,
  output logic                   arb_switch
);

  logic [NUM_MASTERS-1:0] req;
  logic [OWNER_W-1:0]     owner_next;
  logic [OWNER_W-1:0]     cand;
  logic [7:0]             tenure;
  logic [7:0]             tenure_next;
  logic                   owner_req;
  logic                   others_req;
  logic                   hold_ok;
  logic                   locked;
  logic                   found;

  assign req = ~m_req_;

  always_comb begin
    owner_req  = req[owner];
    others_req = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (OWNER_W'(i) != owner && req[i]) others_req = 1'b1;
    end
  end

  // The owner may keep the bus until its tenure reaches MAX_HOLD-1; MAX_HOLD of 0 means no limit.
  assign hold_ok = (MAX_HOLD == 0) || (int'(tenure) < MAX_HOLD - 1);

`ifdef BUS_ARB_LOCK_EN
  assign locked = owner_req & ~m_lock_[owner];
`else
  assign locked = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= '0;
      tenure     <= '0;
      arb_switch <= 1'b0;
    end else begin
      owner      <= owner_next;
      tenure     <= tenure_next;
      arb_switch <= (owner_next != owner);
    end
  end

  // Next-state logic: the scan starts one past the owner so the owner is considered last.
  always_comb begin
    owner_next = owner;
    cand       = '0;
    found      = 1'b0;
    if (owner_req && (hold_ok || !others_req || locked)) begin
      owner_next = owner;
    end else if (others_req) begin
      for (int i = 1; i < NUM_MASTERS; i++) begin
        cand = OWNER_W'((int'(owner) + i) % NUM_MASTERS);
        if (!found && req[cand]) begin
          found      = 1'b1;
          owner_next = cand;
        end
      end
    end
  end

  always_comb begin
    if (owner_next != owner)  tenure_next = 8'd0;
    else if (!owner_req)      tenure_next = 8'd0;
    else if (tenure == 8'hFF) tenure_next = tenure;
    else                      tenure_next = tenure + 8'd1;
  end

  // Output decode: exactly one grant low at all times.
  always_comb begin
    m_grnt_        = '1;
    m_grnt_[owner] = 1'b0;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised round-robin bus arbiter for the shared system bus. Serves NUM_MASTERS bus masters.
- Grants exactly one master at any time, using active-low request and grant signals.
- Adds a maximum-tenure limit so one master cannot starve the others.
- Sits between the bus masters and the bus address/data multiplexers. The registered owner index drives the mux selects.

Parameters:
- NUM_MASTERS, 4: number of masters; legal range 2..16.
- OWNER_W, $clog2(NUM_MASTERS): width of the owner index. Derived; do not override.
- MAX_HOLD, 16: maximum consecutive granted cycles while another master is waiting. 0 disables preemption. Legal range 0..255.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- m_req_  input  NUM_MASTERS  per-master bus request, active-low (0 = request)
- m_lock_  input  NUM_MASTERS  per-master bus lock, active-low; present only with BUS_ARB_LOCK_EN
- m_grnt_  output  NUM_MASTERS  per-master grant, active-low, one-cold
- owner  output  OWNER_W  registered index of the current owner
- arb_switch  output  1  registered one-cycle pulse when owner changed on the last edge

Behaviour:
- Reset values (sampled at posedge clk while reset=1):
  - owner = 0, so m_grnt_ = all ones except bit 0 = 0.
  - tenure = 0.
  - arb_switch = 0.
- Reset asserted mid-tenure forces these values on the next edge, regardless of m_req_.
- m_grnt_ is decoded combinationally from owner:
  - bit owner = 0, all other bits = 1.
  - Exactly one bit is low in every cycle, including reset. No grant-free cycle ever occurs.
- Arbitration is evaluated every posedge clk; the new owner is visible in the same cycle the register updates.
- Latency from a request to its grant on an idle bus is 1 clock.
- Next-owner rules, applied in order:
  1. The owner requests, and either tenure < MAX_HOLD-1, MAX_HOLD = 0, or no other master requests: keep the owner.
  2. Otherwise, if any other master requests: select the first requester scanning owner+1, owner+2, ... with modulo NUM_MASTERS wrap. The current owner is checked last.
  3. No master requests: owner unchanged (grant parks on the last owner).
- tenure is an 8-bit counter:
  - Increments when the owner is kept and is requesting.
  - Clears to 0 on any owner change, and when the owner does not request.
  - Saturates at 255.
- Preemption occurs on the edge where tenure == MAX_HOLD-1 and another master requests. The owner thus holds at most MAX_HOLD consecutive granted-and-requesting cycles.
- Simultaneous requests: rotation order decides, never the index value alone. Every waiting master is granted within (NUM_MASTERS-1)*MAX_HOLD + 1 cycles.
- The owner drops its request on the same edge another master raises one: handover on that edge. There is no idle cycle.
- arb_switch = 1 for exactly one cycle after each edge where owner changed; otherwise 0.
- Bit widths: owner increments and wraps modulo NUM_MASTERS; index NUM_MASTERS or above never occurs. Non-power-of-2 NUM_MASTERS must wrap correctly (e.g. 3 -> 0 for NUM_MASTERS = 4 only at 3, and 2 -> 0 for NUM_MASTERS = 3).

Optional Feature:
- Macro: BUS_ARB_LOCK_EN.
- Defined:
  - Port m_lock_ exists.
  - While m_lock_[owner] = 0 and m_req_[owner] = 0, rule 2 preemption is suppressed.
  - tenure still counts and saturates.
  - Lock by a non-owner has no effect.
  - Releasing the lock with tenure at or above MAX_HOLD-1 and another requester pending causes handover on the next edge.
- Undefined: m_lock_ port is absent, and preemption is governed by MAX_HOLD only.

Test Plan (NUM_MASTERS=4, MAX_HOLD=4 unless stated):
- Reset, then m_req_=4'b1111 for 5 cycles -> m_grnt_=4'b1110, owner=0, arb_switch=0 throughout.
- owner=0 idle; assert m_req_=4'b0101 (masters 1 and 3) -> next edge owner=1, m_grnt_=4'b1101, arb_switch pulses once. Master 1 releases -> owner=3.
- Masters 0 and 2 request continuously from owner=0 -> owner sequence 0,0,0,0,2,2,2,2,0: exactly 4 cycles each.
- MAX_HOLD=0, masters 1 and 2 both requesting, owner=1 -> owner stays 1 for 100 cycles, and no arb_switch pulse.
- NUM_MASTERS=3, owner=2, only master 0 requests -> owner wraps to 0. owner never reaches 3 under random 1000-cycle stimulus, and m_grnt_ is always one-cold.
- BUS_ARB_LOCK_EN: owner=1 locked and requesting, master 2 requesting -> owner held 10 cycles past MAX_HOLD. Lock released -> owner=2 on the next edge. Reset asserted mid-lock -> owner=0.
